// File: rtl/a4092_pkg.sv
// rtl/a4092_pkg.sv - shared types and defaults for the A4092 local bus sequencer
//
// Contents:
//   lbs_state_t        sequencer state encoding, also exported on state_dbg
//   TURN_CYCLES_DEF    default buffer turnaround length in CLK_50M cycles
//   GRANT_TIMEOUT_DEF  default SBG_n-to-MASTER_n allowance in CLK_50M cycles
package a4092_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SLAVE   = 3'd1,
        ST_ZREQ    = 3'd2,
        ST_ZWAIT   = 3'd3,
        ST_TURN_IN = 3'd4,
        ST_DMA     = 3'd5,
        ST_RELEASE = 3'd6
    } lbs_state_t;

    localparam int TURN_CYCLES_DEF   = 2;
    localparam int GRANT_TIMEOUT_DEF = 255;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer bank with per-bit reset value
//
// Ports:
//   CLK_50M   in   clock
//   IORST_n   in   asynchronous active-low reset, loads RESET_VAL into both stages
//   d         in   WIDTH asynchronous inputs
//   q         out  WIDTH synchronized outputs (two CLK_50M cycles of latency)
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK_50M,
    input  logic             IORST_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLK_50M or negedge IORST_n) begin
        if (!IORST_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/local_bus_sequencer.sv
// rtl/local_bus_sequencer.sv - arbitrates the A4092 local bus between host slave cycles and 53C710 DMA
//
// Ports:
//   CLK_50M     in   clock
//   IORST_n     in   asynchronous active-low reset
//   slave_req   in   host cycle decoded for this card (synchronous)
//   slave_end   in   host cycle finished (synchronous)
//   SBR_n       in   SCSI bus request (asynchronous)
//   MASTER_n    in   SCSI chip drives the local bus (asynchronous)
//   Z_BG_n      in   Zorro bus grant (asynchronous)
//   z_bus_idle  in   Zorro FCS and DTACK both negated (asynchronous)
//   SBG_n       out  SCSI bus grant
//   Z_BR_n      out  Zorro bus request
//   MYBUS_n     out  card is Zorro bus master
//   slave_ok    out  slave cycle may proceed
//   turn        out  turnaround active, all transceivers off
//   grant_err   out  one-cycle pulse when a grant times out unused
//   state_dbg   out  current state encoding
module local_bus_sequencer
    import a4092_pkg::*;
#(
    parameter int TURN_CYCLES   = TURN_CYCLES_DEF,
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
    parameter int CNT_W         = 8
) (
    input  logic       CLK_50M,
    input  logic       IORST_n,
    input  logic       slave_req,
    input  logic       slave_end,
    input  logic       SBR_n,
    input  logic       MASTER_n,
    input  logic       Z_BG_n,
    input  logic       z_bus_idle,
    output logic       SBG_n,
    output logic       Z_BR_n,
    output logic       MYBUS_n,
    output logic       slave_ok,
    output logic       turn,
    output logic       grant_err,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(GRANT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic       sbr_s;
    logic       master_s;
    logic       zbg_s;
    logic       idle_s;

    lbs_state_t       state;
    lbs_state_t       nxt;
    logic [CNT_W-1:0] cnt;
    logic             master_seen;
    logic             timeout;

    // Active-low strobes park high, z_bus_idle parks low (bus assumed busy).
    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1110)
    ) u_sync (
        .CLK_50M (CLK_50M),
        .IORST_n (IORST_n),
        .d       ({SBR_n, MASTER_n, Z_BG_n, z_bus_idle}),
        .q       ({sbr_s, master_s, zbg_s, idle_s})
    );

    always_comb begin
        nxt     = state;
        timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                // The host cycle is already on the bus, so it beats a new DMA request.
                if (slave_req)   nxt = ST_SLAVE;
                else if (!sbr_s) nxt = ST_ZREQ;
            end
            ST_SLAVE: begin
                if (slave_end) nxt = ST_IDLE;
            end
            ST_ZREQ: begin
                if (slave_req)   nxt = ST_SLAVE;
                else if (sbr_s)  nxt = ST_IDLE;
                else if (!zbg_s) nxt = ST_ZWAIT;
            end
            ST_ZWAIT: begin
                if (idle_s) nxt = ST_TURN_IN;
            end
            ST_TURN_IN: begin
                if (cnt == TURN_LAST) nxt = ST_DMA;
            end
            ST_DMA: begin
                // Tenure ends only after the chip has actually mastered and let go;
                // if SBR_n is still low the chip keeps the grant for another burst.
                if (master_seen && master_s && sbr_s) begin
                    nxt = ST_RELEASE;
                end else if (!master_seen && master_s && cnt == TIMEOUT_VAL) begin
                    nxt     = ST_RELEASE;
                    timeout = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt == TURN_LAST) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge IORST_n) begin
        if (!IORST_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            master_seen <= 1'b0;
            SBG_n       <= 1'b1;
            Z_BR_n      <= 1'b1;
            MYBUS_n     <= 1'b1;
            slave_ok    <= 1'b0;
            turn        <= 1'b0;
            grant_err   <= 1'b0;
        end else begin
            state <= nxt;

            // Shared counter: restarts on every state change, freezes once the
            // chip has taken the bus in DMA, and saturates instead of wrapping.
            if (nxt != state) begin
                cnt <= '0;
            end else if (!(state == ST_DMA && (master_seen || !master_s)) && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (nxt != state) begin
                master_seen <= 1'b0;
            end else if (state == ST_DMA && !master_s) begin
                master_seen <= 1'b1;
            end

            // Outputs follow the next state so they switch on the same edge as the state.
            SBG_n     <= (nxt != ST_DMA);
            Z_BR_n    <= !(nxt == ST_ZREQ || nxt == ST_ZWAIT);
            MYBUS_n   <= !(nxt == ST_TURN_IN || nxt == ST_DMA);
            slave_ok  <= (nxt == ST_SLAVE);
            turn      <= (nxt == ST_TURN_IN || nxt == ST_RELEASE);
            grant_err <= timeout;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_local_bus_sequencer.sv
// tb/tb_local_bus_sequencer.sv - self-checking bench for local_bus_sequencer
module tb_local_bus_sequencer;
    import a4092_pkg::*;

    localparam int TURN = TURN_CYCLES_DEF;
    localparam int TMO  = GRANT_TIMEOUT_DEF;

    logic       CLK_50M    = 1'b0;
    logic       IORST_n    = 1'b0;
    logic       slave_req  = 1'b0;
    logic       slave_end  = 1'b0;
    logic       SBR_n      = 1'b1;
    logic       MASTER_n   = 1'b1;
    logic       Z_BG_n     = 1'b1;
    logic       z_bus_idle = 1'b0;
    logic       SBG_n;
    logic       Z_BR_n;
    logic       MYBUS_n;
    logic       slave_ok;
    logic       turn;
    logic       grant_err;
    logic [2:0] state_dbg;

    int err_cnt  = 0;
    int chk_cnt  = 0;
    int inv_bad  = 0;
    int gerr_seen = 0;
    int sbg_low_seen = 0;

    local_bus_sequencer u_dut (
        .CLK_50M    (CLK_50M),
        .IORST_n    (IORST_n),
        .slave_req  (slave_req),
        .slave_end  (slave_end),
        .SBR_n      (SBR_n),
        .MASTER_n   (MASTER_n),
        .Z_BG_n     (Z_BG_n),
        .z_bus_idle (z_bus_idle),
        .SBG_n      (SBG_n),
        .Z_BR_n     (Z_BR_n),
        .MYBUS_n    (MYBUS_n),
        .slave_ok   (slave_ok),
        .turn       (turn),
        .grant_err  (grant_err),
        .state_dbg  (state_dbg)
    );

    always #10 CLK_50M = ~CLK_50M;

    // Ownership invariants and event tallies, sampled mid-cycle.
    always @(negedge CLK_50M) begin
        if (IORST_n) begin
            if (slave_ok && !MYBUS_n) inv_bad++;
            if (!SBG_n && turn)       inv_bad++;
            if (grant_err)            gerr_seen++;
            if (!SBG_n)               sbg_low_seen++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    // Raise SBR_n and walk the card through Zorro acquisition into DMA.
    // bg_delay: cycles between Z_BR_n low and Z_BG_n low.
    // idle_delay: cycles between Z_BG_n low and z_bus_idle high.
    task automatic to_dma(input int bg_delay, input int idle_delay);
        int k;
        int exp_k;
        SBR_n = 1'b0;
        k = 0;
        while (Z_BR_n && k < 10) begin tick(); k++; end
        check("sbr_to_zbr", k, 3);
        repeat (bg_delay) tick();
        check("zreq_outs", int'({Z_BR_n, MYBUS_n, SBG_n}), 3);
        check("zreq_state", int'(state_dbg), 2);
        Z_BG_n = 1'b0;
        if (idle_delay == 0) z_bus_idle = 1'b1;
        k = 0;
        while (MYBUS_n && k < 40) begin
            tick();
            k++;
            if (k == idle_delay) z_bus_idle = 1'b1;
        end
        // grant synced (2) then ZREQ->ZWAIT (1) then ZWAIT->TURN_IN (1);
        // idle synced (2) then ZWAIT->TURN_IN (1).
        exp_k = (idle_delay + 3 > 4) ? idle_delay + 3 : 4;
        check("bg_idle_to_mybus", k, exp_k);
        check("turnin_outs", int'({Z_BR_n, SBG_n, turn}), 7);
        check("turnin_state", int'(state_dbg), 4);
        k = 0;
        while (SBG_n && k < 20) begin tick(); k++; end
        check("mybus_to_sbg", k, TURN);
        check("dma_state", int'(state_dbg), 5);
        check("dma_turn_off", int'(turn), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        int len;
        int ok_n;
        int zb_n;
        int g0;
        int early;

        // Reset values
        #25;
        check("rst_outs", int'({SBG_n, Z_BR_n, MYBUS_n, slave_ok, turn, grant_err}), 6'b111000);
        check("rst_state", int'(state_dbg), 0);
        @(posedge CLK_50M); #1;
        IORST_n = 1'b1;
        repeat (3) tick();
        check("idle_state", int'(state_dbg), 0);

        // Host slave cycles of random length
        for (int r = 0; r < 3; r++) begin
            len  = $urandom_range(3, 15);
            ok_n = 0;
            zb_n = 0;
            slave_req = 1'b1;
            for (int i = 0; i < len; i++) begin
                tick();
                if (i == 0) check("slave_ok_latency", int'(slave_ok), 1);
                if (slave_ok) ok_n++;
                if (!Z_BR_n)  zb_n++;
            end
            check("slave_ok_cycles", ok_n, len);
            check("slave_no_zbr", zb_n, 0);
            slave_req = 1'b0;
            slave_end = 1'b1;
            tick();
            slave_end = 1'b0;
            check("slave_end_ok", int'(slave_ok), 0);
            check("slave_end_state", int'(state_dbg), 0);
            tick();
        end

        // Full DMA tenures with random timing
        for (int r = 0; r < 4; r++) begin
            to_dma($urandom_range(0, 6), $urandom_range(0, 5));
            repeat ($urandom_range(0, 20)) tick();
            MASTER_n = 1'b0;
            len   = $urandom_range(1, 25);
            early = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                tick();
                if (early == 1 && i == 0) SBR_n = 1'b1;
            end
            check("tenure_hold", int'({SBG_n, MYBUS_n}), 0);
            MASTER_n = 1'b1;
            SBR_n    = 1'b1;
            k = 0;
            while (!MYBUS_n && k < 20) begin tick(); k++; end
            check("master_rise_to_mybus", k, 3);
            check("release_outs", int'({SBG_n, Z_BR_n, turn, grant_err}), 4'b1110);
            check("release_state", int'(state_dbg), 6);
            n = 0;
            while (turn && n < 20) begin tick(); n++; end
            check("release_turn_cycles", n, TURN);
            check("release_to_idle", int'(state_dbg), 0);
            Z_BG_n     = 1'b1;
            z_bus_idle = 1'b0;
            repeat (3) tick();
            check("post_dma_idle", int'({state_dbg, Z_BR_n}), 1);
        end

        // slave_req and SBR_n together: host first, ZREQ after slave_end
        slave_req = 1'b1;
        SBR_n     = 1'b0;
        tick();
        check("tie_slave_first", int'(state_dbg), 1);
        check("tie_slave_ok", int'(slave_ok), 1);
        repeat ($urandom_range(4, 10)) tick();
        check("tie_zbr_held", int'(Z_BR_n), 1);
        slave_req = 1'b0;
        slave_end = 1'b1;
        tick();
        slave_end = 1'b0;
        check("tie_back_idle", int'(state_dbg), 0);
        tick();
        check("tie_zreq_next", int'(state_dbg), 2);
        check("tie_zbr_low", int'(Z_BR_n), 0);

        // Host cycle arriving during ZREQ takes the bus, request re-raised afterwards
        slave_req = 1'b1;
        tick();
        check("preempt_state", int'(state_dbg), 1);
        check("preempt_outs", int'({Z_BR_n, slave_ok}), 3);
        slave_req = 1'b0;
        slave_end = 1'b1;
        tick();
        slave_end = 1'b0;
        tick();
        check("preempt_rerequest", int'({state_dbg, Z_BR_n}), 4);

        // Request withdrawn in ZREQ
        g0 = sbg_low_seen;
        SBR_n = 1'b1;
        k = 0;
        while (!Z_BR_n && k < 10) begin tick(); k++; end
        check("withdraw_zbr", k, 3);
        check("withdraw_state", int'(state_dbg), 0);
        repeat (4) tick();
        check("withdraw_no_sbg", sbg_low_seen - g0, 0);

        // Grant never used: timeout
        to_dma(2, 1);
        g0 = gerr_seen;
        SBR_n = 1'b1;
        n = 0;
        while (!SBG_n && n < 400) begin tick(); n++; end
        check("timeout_sbg_low_cycles", n, TMO + 1);
        check("timeout_pulse", int'(grant_err), 1);
        check("timeout_release", int'({state_dbg, MYBUS_n}), 13);
        tick();
        check("timeout_pulse_end", int'(grant_err), 0);
        repeat (TURN - 1) tick();
        check("timeout_to_idle", int'(state_dbg), 0);
        check("timeout_pulse_count", gerr_seen - g0, 1);
        Z_BG_n     = 1'b1;
        z_bus_idle = 1'b0;
        repeat (3) tick();

        // Reset during DMA clears grants without a clock edge
        to_dma(0, 0);
        MASTER_n = 1'b0;
        repeat (5) tick();
        #3;
        IORST_n = 1'b0;
        #1;
        check("rst_dma_grants", int'({SBG_n, Z_BR_n, MYBUS_n}), 7);
        check("rst_dma_state", int'({state_dbg, turn, slave_ok}), 0);
        MASTER_n   = 1'b1;
        SBR_n      = 1'b1;
        Z_BG_n     = 1'b1;
        z_bus_idle = 1'b0;
        repeat (2) tick();
        IORST_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", int'({state_dbg, SBG_n, MYBUS_n}), 3);

        check("ownership_invariants", inv_bad, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
